// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_pkg
//  Description : Shared AXI4 types and the beat-address helper used by the
//                write responder and the burst address generator.
//  Revision    : 1.0  initial release
// ============================================================================
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

  // Address of the beat following 'addr'. WRAP assumes a power-of-two beat
  // count; illegal WRAP lengths are suppressed by the caller anyway.
  function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                 input logic [7:0]  len,
                                                 input logic [2:0]  size,
                                                 input burst_e      burst);
    logic [63:0] step;
    logic [63:0] wrap_bytes;
    logic [63:0] mask;
    step       = 64'd1 << size;
    wrap_bytes = ({56'd0, len} + 64'd1) << size;
    mask       = wrap_bytes - 64'd1;
    case (burst)
      BURST_INCR: next_beat_addr = addr + step;
      BURST_WRAP: next_beat_addr = (addr & ~mask) | ((addr + step) & mask);
      default:    next_beat_addr = addr;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_burst_addr_gen
//  Description : Captures AxADDR/LEN/SIZE/BURST, walks the beat address and
//                flags bursts that cannot be executed on this data width.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STRB_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [7:0]        len_o,
  output logic              illegal_o
);

  localparam int unsigned SIZE_MAX = $clog2(STRB_W);

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  burst_e            burst_q;
  logic              illegal_q;
  logic              illegal_d;

  // Classify the incoming burst: oversize beat, reserved type, bad WRAP length.
  always_comb begin
    illegal_d = 1'b0;
    if (size_i > 3'(SIZE_MAX))
      illegal_d = 1'b1;
    if (burst_e'(burst_i) == BURST_RSVD)
      illegal_d = 1'b1;
    if ((burst_e'(burst_i) == BURST_WRAP) &&
        !(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}))
      illegal_d = 1'b1;
  end

  // Load burst attributes on AW, step the address on every accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      illegal_q <= 1'b0;
    end else if (load_i) begin
      addr_q    <= addr_i;
      len_q     <= len_i;
      size_q    <= size_i;
      burst_q   <= burst_e'(burst_i);
      illegal_q <= illegal_d;
    end else if (advance_i) begin
      addr_q    <= ADDR_W'(next_beat_addr(64'(addr_q), len_q, size_q, burst_q));
    end
  end

  assign cur_addr_o = addr_q;
  assign len_o      = len_q;
  assign illegal_o  = illegal_q;

endmodule
`default_nettype wire

// File: rtl/axi4_wr_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_wr_responder
//  Description : AXI4 subordinate write responder. Terminates AW/W/B, one
//                burst in flight, and issues one SRAM write per data beat.
//                Optional address window check: AXI4_WR_RESP_ADDR_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_wr_responder
  import axi4_pkg::*;
#(
  parameter int unsigned       ID_W       = 8,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       MEM_AW     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] SIZE_BYTES = ADDR_W'(32'h8000)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [7:0]          aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;
  resp_e             resp_q, resp_d;
  logic              live_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        burst_len;
  logic              illegal;
  logic              beat_blocked;
  logic              suppress;
  logic              aw_hs;
  logic              w_hs;
  logic              last_by_count;

  assign aw_hs         = aw_valid & aw_ready;
  assign w_hs          = w_valid & w_ready;
  assign last_by_count = (beat_q == burst_len);

  axi4_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .STRB_W (STRB_W)
  ) u_addr_gen (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (aw_hs),
    .addr_i     (aw_addr),
    .len_i      (aw_len),
    .size_i     (aw_size),
    .burst_i    (aw_burst),
    .advance_i  (w_hs),
    .cur_addr_o (cur_addr),
    .len_o      (burst_len),
    .illegal_o  (illegal)
  );

`ifdef AXI4_WR_RESP_ADDR_CHECK_EN
  logic oow_q;
  logic in_win;

  assign in_win       = (cur_addr >= BASE_ADDR) && ((cur_addr - BASE_ADDR) < SIZE_BYTES);
  assign beat_blocked = oow_q | ~in_win;

  // Once a beat leaves the window, every remaining beat of the burst is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      oow_q <= 1'b0;
    else if (aw_hs)
      oow_q <= 1'b0;
    else if (w_hs && !in_win)
      oow_q <= 1'b1;
  end
`else
  logic unused_win;
  assign unused_win   = ^{BASE_ADDR, SIZE_BYTES};
  assign beat_blocked = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^cur_addr;

  assign suppress = illegal | beat_blocked;

  // State, beat count, error flag, captured ID and registered response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      err_q   <= 1'b0;
      resp_q  <= RESP_OKAY;
      id_q    <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      live_q  <= 1'b1;
      if (aw_hs)
        id_q <= aw_id;
    end
  end

  // Next-state logic; a burst closes on w_last or on the final counted beat.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          state_d = ST_DATA;
          beat_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          err_d  = err_q | suppress;
          if (w_last || last_by_count) begin
            state_d = ST_RESP;
            resp_d  = (err_q || suppress || (w_last != last_by_count)) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (b_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign aw_ready  = live_q && (state_q == ST_IDLE);
  assign w_ready   = (state_q == ST_DATA);
  assign b_valid   = (state_q == ST_RESP);
  assign b_id      = id_q;
  assign b_resp    = resp_q;
  assign mem_we    = w_valid & w_ready & ~suppress;
  assign mem_addr  = cur_addr[ADDR_LSB +: MEM_AW];
  assign mem_wdata = w_data;
  assign mem_wstrb = w_strb;

endmodule
`default_nettype wire

// File: doc/axi4_wr_responder.md
Name:
axi4_wr_responder

Overview:
AXI4 subordinate-side write responder: terminates the AW/W/B channels that the core-side AXI4 port drives, and converts bursts into per-beat writes on a simple single-port SRAM write interface. Sits at the target end of the core's AXI4 write path, on a memory or peripheral port of the eval platform. One burst in flight; AxCACHE/AxPROT/AxQOS/AxLOCK are not connected.

Parameters:
ID_W, 8, AWID/BID width
ADDR_W, 32, byte address width
DATA_W, 64, data width (power of 2, ≥ 32); STRB_W = DATA_W/8
MEM_AW, 12, SRAM word-address width
BASE_ADDR / SIZE_BYTES, 32'h0 / 32'h8000, decode window (used only with the option)

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
aw_valid  in  1  AW valid
aw_ready  out  1  AW ready
aw_id  in  ID_W  write ID
aw_addr  in  ADDR_W  start byte address
aw_len  in  8  beats-1
aw_size  in  3  log2 bytes per beat
aw_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
w_valid  in  1  W valid
w_ready  out  1  W ready
w_data  in  DATA_W  write data
w_strb  in  STRB_W  byte strobes
w_last  in  1  last beat
b_valid  out  1  B valid
b_ready  in  1  B ready
b_id  out  ID_W  response ID (= captured aw_id)
b_resp  out  2  00 OKAY, 10 SLVERR
mem_we  out  1  SRAM write enable, one beat
mem_addr  out  MEM_AW  SRAM word address
mem_wdata  out  DATA_W  = w_data
mem_wstrb  out  STRB_W  = w_strb

Behaviour:
- Reset (async assert, sync release): state IDLE; aw_ready=0, w_ready=0, b_valid=0, b_id=0, b_resp=00, mem_we=0. aw_ready first rises in the first cycle after reset_n deasserts.
- FSM IDLE→DATA→RESP→IDLE. IDLE: aw_ready=1, w_ready=0. On the AW handshake, capture id/addr/len/size/burst, clear beat counter and error flag, go to DATA. W is never accepted before its AW (no write-data buffering).
- DATA: w_ready=1. Each W handshake: mem_we=w_valid (combinational) unless the burst is suppressed; mem_addr = cur_addr[log2(STRB_W)+:MEM_AW]; strobes pass through unchanged; beat counter increments; address advances.
- Address step = 1<<size. FIXED: unchanged. INCR: +step, no 4 KB check. WRAP: boundary = (len+1)<<size; addr = aligned base + ((addr+step) mod boundary).
- Burst ends at beat==len or on w_last, whichever comes first → RESP. A w_last/beat-count mismatch (early or missing w_last) sets SLVERR; beats already written stay written.
- Suppressed bursts (all beats accepted, mem_we=0, SLVERR): size > log2(STRB_W); burst==11; WRAP with len∉{1,3,7,15}.
- RESP: b_valid=1; b_id/b_resp held stable until b_ready; then IDLE. aw_ready reasserts the cycle after the B handshake.
- Minimum latency: AW in cycle 0, W in cycle 1, b_valid in cycle 2; back-to-back single-beat bursts take 3 cycles each.
- Reset mid-burst: everything returns to reset values immediately; a partially written burst is not rolled back.

Optional Feature:
AXI4_WR_RESP_ADDR_CHECK_EN: when defined, aw_addr is checked against [BASE_ADDR, BASE_ADDR+SIZE_BYTES). If the start address is outside the window, the whole burst is suppressed with SLVERR. If a later beat crosses the window's end, that beat and all remaining beats are suppressed with SLVERR. When not defined, no decode is done and all legal bursts return OKAY.

Decomposition:
- Package axi4_pkg: burst_e (FIXED/INCR/WRAP/RSVD), resp_e (OKAY/EXOKAY/SLVERR/DECERR), wr_state_e, helper function for next beat address.
- One sub-module, axi4_burst_addr_gen: captures addr/len/size/burst, produces cur_addr and an illegal-burst flag. It is reusable by a future read responder.

Test Plan:
- Single beat: AW addr 0x40, len 0, size 3, INCR, id 0x5A; W strb 0xFF, last=1 → mem_we one cycle at mem_addr 0x8; b_valid in cycle 2; b_id 0x5A; b_resp 00.
- INCR 4 beats at 0x100, size 3 → mem_addr 0x20, 0x21, 0x22, 0x23; OKAY. Hold b_ready low 5 cycles → B stable and aw_ready=0 throughout.
- WRAP len 3, size 3 at 0x118 → mem_addr 0x23, 0x20, 0x21, 0x22. WRAP len 2 → no mem_we, SLVERR.
- w_last on beat 2 of len 3 → 2 writes, then B SLVERR. aw_size 4 on 64-bit bus → all beats accepted, no mem_we, SLVERR.
- Reset asserted mid-burst (after beat 1 of 4) → outputs at reset values the same cycle; the next burst completes normally with OKAY.
- With AXI4_WR_RESP_ADDR_CHECK_EN and SIZE 0x8000: INCR len 3 at 0x7FF0 → 2 writes, last 2 beats suppressed, SLVERR; addr 0x9000 → no writes, SLVERR.
